st_trace_capture: RTL and testbench

- Sits directly downstream of the core's EM-stage store port. Captures every store that hits the trace window (MADDR[31:20] == WIN_BASE) into a FIFO and streams it out over a valid/ready interface.
- Replaces the simulation-only store printout with synthesizable observation logic.
- Watches PC_IF for the halt address. On halt it stops capture, drains the FIFO, then raises DONE.

---
 rtl/st_trace_capture.sv | 139 +++++++++++++
 tb/tb_st_trace_capture.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_trace_capture.sv
// Store-trace capture: window-filtered stores from the EM-stage port are queued in a FIFO
// and streamed over valid/ready; a fetch of the halt PC stops capture, drains, then flags DONE.
`timescale 1ns/1ps

module st_trace_capture #(
    parameter int          DEPTH    = 16,
    parameter logic [11:0] WIN_BASE = 12'h001,
    parameter logic [31:0] HALT_PC  = 32'h00000064,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      PC_IF,
    input  logic             ST_EN,
    input  logic [31:0]      MADDR,
    input  logic [31:0]      MDATAO,
    input  logic [3:0]       MWSTB,
    output logic             TRACE_VALID,
    input  logic             TRACE_READY,
    output logic [67:0]      TRACE_DATA,
    output logic [CNT_W-1:0] DROP_CNT,
    output logic             HALTED,
    output logic             DONE
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 68;
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [AW:0]       wr_ptr_next;
    logic [AW:0]       rd_ptr_next;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     data_reg;
    logic [CNT_W-1:0]  drop_reg;
    logic              halted_reg;
    logic              done_reg;

    logic              empty;
    logic              full;
    logic              cap;
    logic              pop;
    logic              push;
    logic              fwd;
    logic              empty_next;
    logic [EW-1:0]     entry;

    assign entry = {MADDR, MDATAO, MWSTB};

    // One extra pointer bit separates full (MSBs differ) from empty (identical).
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign cap  = ST_EN && (MADDR[31:20] == WIN_BASE) && (state_reg == S_RUN);
    assign pop  = !empty && TRACE_READY;
    assign push = cap && (!full || pop);

    assign wr_ptr_next = push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    assign rd_ptr_next = pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
    assign empty_next  = (wr_ptr_next == rd_ptr_next);

    // The entry being written lands exactly where the next head will be read from.
    assign fwd = push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem[wr_ptr_reg[AW-1:0]] <= entry;
        end
    end

    // Head register: registered RAM read addressed by the next read pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg <= '0;
        end else if (fwd) begin
            data_reg <= entry;
        end else begin
            data_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            drop_reg   <= '0;
            state_reg  <= S_RUN;
            halted_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;

            if (cap && full && !pop && (drop_reg != '1)) begin
                drop_reg <= drop_reg + CNT_ONE;
            end

            case (state_reg)
                S_RUN: begin
                    if (PC_IF == HALT_PC) begin
                        state_reg  <= S_DRAIN;
                        halted_reg <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (empty_next) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg  <= S_RUN;
                    halted_reg <= 1'b0;
                    done_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign TRACE_VALID = !empty;
    assign TRACE_DATA  = data_reg;
    assign DROP_CNT    = drop_reg;
    assign HALTED      = halted_reg;
    assign DONE        = done_reg;

endmodule

// File: tb/tb_st_trace_capture.sv
// Bench for st_trace_capture: constant vector table, directed multi-cycle sequences and
// randomized traffic compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_st_trace_capture;

    localparam int          DEPTH = 16;
    localparam int          CW    = 4;
    localparam logic [31:0] HPC   = 32'h00000064;
    localparam logic [11:0] WIN   = 12'h001;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [31:0]   PC_IF = '0;
    logic          ST_EN = 1'b0;
    logic [31:0]   MADDR = '0;
    logic [31:0]   MDATAO = '0;
    logic [3:0]    MWSTB = '0;
    logic          TRACE_VALID;
    logic          TRACE_READY = 1'b0;
    logic [67:0]   TRACE_DATA;
    logic [CW-1:0] DROP_CNT;
    logic          HALTED;
    logic          DONE;

    always #5 CLK = ~CLK;

    st_trace_capture #(
        .DEPTH(DEPTH), .WIN_BASE(WIN), .HALT_PC(HPC), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .PC_IF(PC_IF), .ST_EN(ST_EN), .MADDR(MADDR),
        .MDATAO(MDATAO), .MWSTB(MWSTB), .TRACE_VALID(TRACE_VALID),
        .TRACE_READY(TRACE_READY), .TRACE_DATA(TRACE_DATA), .DROP_CNT(DROP_CNT),
        .HALTED(HALTED), .DONE(DONE)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: the FIFO is a plain queue, the run state two flags.
    logic [67:0] mq[$];
    int          m_drop = 0;
    bit          m_halted = 0;
    bit          m_done = 0;

    task automatic model_update();
        bit pop;
        bit cap;
        bit was_full;
        pop      = (mq.size() > 0) && TRACE_READY;
        cap      = ST_EN && (MADDR[31:20] == WIN) && !m_halted;
        was_full = (mq.size() == DEPTH);
        if (RST) begin
            mq.delete();
            m_drop = 0; m_halted = 0; m_done = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!was_full || pop) mq.push_back({MADDR, MDATAO, MWSTB});
                else if (m_drop < (1 << CW) - 1) m_drop++;
            end
            if (!m_halted) begin
                if (PC_IF == HPC) m_halted = 1;
            end else if (!m_done && mq.size() == 0) begin
                m_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CW-1:0] d;
        d = m_drop[CW-1:0];
        chk({tag, ".valid"}, TRACE_VALID, mq.size() > 0);
        if (mq.size() > 0) chk({tag, ".data"}, TRACE_DATA, mq[0]);
        chk({tag, ".drop"}, DROP_CNT, d);
        chk({tag, ".halted"}, HALTED, m_halted);
        chk({tag, ".done"}, DONE, m_done);
    endtask

    task automatic set_idle();
        ST_EN = 1'b0; MADDR = '0; MDATAO = '0; MWSTB = '0; PC_IF = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ST_EN = 1'b1; MADDR = a; MDATAO = d; MWSTB = s;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1'b1; ST_EN = 1'bx;
        tick();
        check_model("reset");
        RST = 1'b0; ST_EN = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic          halt;
        logic          st_en;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic          ready;
        logic          exp_valid;
        logic [67:0]   exp_data;
        logic [CW-1:0] exp_drop;
        logic          exp_halted;
        logic          exp_done;
    } vec_t;

    vec_t vt[12];

    initial begin
        int beats;
        int ok;
        // rst halt st  addr           data           strb  rdy | valid data                                       drop h d
        vt[0]  = '{1, 0, 0, 32'h0,        32'h0,        4'h0, 0,  0, 68'h0,                                      0, 0, 0};
        vt[1]  = '{0, 0, 1, 32'h00100010, 32'hDEADBEEF, 4'hF, 1,  1, {32'h00100010, 32'hDEADBEEF, 4'hF},         0, 0, 0};
        vt[2]  = '{0, 0, 0, 32'h0,        32'h0,        4'h0, 1,  0, 68'h0,                                      0, 0, 0};
        vt[3]  = '{0, 0, 1, 32'h00200000, 32'h11111111, 4'hF, 1,  0, 68'h0,                                      0, 0, 0};
        vt[4]  = '{0, 0, 1, 32'h00000100, 32'h22222222, 4'hF, 1,  0, 68'h0,                                      0, 0, 0};
        vt[5]  = '{0, 0, 1, 32'h001FFFFC, 32'h12345678, 4'h3, 0,  1, {32'h001FFFFC, 32'h12345678, 4'h3},         0, 0, 0};
        vt[6]  = '{0, 0, 0, 32'h0,        32'h0,        4'h0, 0,  1, {32'h001FFFFC, 32'h12345678, 4'h3},         0, 0, 0};
        vt[7]  = '{0, 0, 1, 32'h00100020, 32'hA5A5A5A5, 4'h1, 1,  1, {32'h00100020, 32'hA5A5A5A5, 4'h1},         0, 0, 0};
        vt[8]  = '{0, 0, 0, 32'h0,        32'h0,        4'h0, 1,  0, 68'h0,                                      0, 0, 0};
        vt[9]  = '{0, 1, 0, 32'h0,        32'h0,        4'h0, 1,  0, 68'h0,                                      0, 1, 0};
        vt[10] = '{0, 0, 0, 32'h0,        32'h0,        4'h0, 1,  0, 68'h0,                                      0, 1, 1};
        vt[11] = '{1, 0, 1, 32'h00100000, 32'h0,        4'h0, 1,  0, 68'h0,                                      0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            RST = vt[i].rst; PC_IF = vt[i].halt ? HPC : 32'h0;
            ST_EN = vt[i].st_en; MADDR = vt[i].addr; MDATAO = vt[i].data; MWSTB = vt[i].strb;
            TRACE_READY = vt[i].ready;
            tick();
            chk($sformatf("vec%0d.valid", i), TRACE_VALID, vt[i].exp_valid);
            if (vt[i].exp_valid || vt[i].rst) chk($sformatf("vec%0d.data", i), TRACE_DATA, vt[i].exp_data);
            chk($sformatf("vec%0d.drop", i), DROP_CNT, vt[i].exp_drop);
            chk($sformatf("vec%0d.halted", i), HALTED, vt[i].exp_halted);
            chk($sformatf("vec%0d.done", i), DONE, vt[i].exp_done);
            $display("[TB] vec %0d: valid=%0b data=%h drop=%0d halted=%0b done=%0b",
                     i, TRACE_VALID, TRACE_DATA, DROP_CNT, HALTED, DONE);
        end
        RST = 1'b0;

        // Overflow: 20 stores into a blocked FIFO, then drain in order.
        do_reset();
        TRACE_READY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            store(32'h00100000 + 32'(i * 4), $urandom, 4'hF);
            tick();
            check_model("ovf.fill");
        end
        chk("ovf.drop4", DROP_CNT, 4);
        set_idle();
        TRACE_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf.order", TRACE_DATA[67:36], 32'h00100000 + 32'(i * 4));
            $display("[TB] ovf beat %0d addr=%h", i, TRACE_DATA[67:36]);
            tick();
            check_model("ovf.drain");
        end
        chk("ovf.empty", TRACE_VALID, 0);

        // Drop counter saturation with a narrow counter.
        TRACE_READY = 1'b0;
        for (int i = 0; i < 36; i++) begin
            store(32'h00100800 + 32'(i), $urandom, 4'h5);
            tick();
            check_model("sat");
        end
        chk("sat.drop15", DROP_CNT, 15);
        $display("[TB] saturation drop=%0d", DROP_CNT);

        // Full FIFO with simultaneous push and pop for 5 cycles.
        do_reset();
        TRACE_READY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            store(32'h00100000 + 32'(i), $urandom, 4'hC);
            tick();
        end
        check_model("fpp.full");
        TRACE_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            store(32'h00100400 + 32'(i), $urandom, 4'hA);
            tick();
            check_model("fpp.swap");
            $display("[TB] full swap %0d head=%h", i, TRACE_DATA[67:36]);
        end
        chk("fpp.drop0", DROP_CNT, 0);
        set_idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            check_model("fpp.drain");
        end
        chk("fpp.empty", TRACE_VALID, 0);

        // Halt with 3 queued plus a cap in the halt cycle; a cap after halt is ignored.
        do_reset();
        TRACE_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h00100100 + 32'(i * 4), $urandom, 4'hF);
            tick();
        end
        store(32'h0010010C, 32'hCAFEF00D, 4'hF);
        PC_IF = HPC;
        tick();
        check_model("halt.edge");
        chk("halt.halted", HALTED, 1);
        PC_IF = 32'h0;
        store(32'h00100110, 32'hBAD0BAD0, 4'hF);
        tick();
        check_model("halt.late");
        set_idle();
        TRACE_READY = 1'b1;
        beats = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (DONE) begin ok = 1; break; end
            if (TRACE_VALID) begin
                beats++;
                $display("[TB] drain beat addr=%h", TRACE_DATA[67:36]);
            end
            tick();
            check_model("halt.drain");
        end
        if (DONE) ok = 1;
        chk("halt.beats", beats, 4);
        chk("halt.done_seen", ok, 1);
        chk("halt.drop0", DROP_CNT, 0);
        PC_IF = HPC;
        store(32'h00100000, 32'h1, 4'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("done.sticky");
        end
        set_idle();

        // Reset in the middle of a drain.
        do_reset();
        TRACE_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            store(32'h00100200 + 32'(i * 4), $urandom, 4'hF);
            tick();
        end
        set_idle();
        PC_IF = HPC;
        tick();
        PC_IF = 32'h0;
        tick();
        check_model("rstd.drain");
        RST = 1'b1;
        tick();
        chk("rstd.valid", TRACE_VALID, 0);
        chk("rstd.halted", HALTED, 0);
        chk("rstd.done", DONE, 0);
        chk("rstd.drop", DROP_CNT, 0);
        RST = 1'b0;
        store(32'h00100300, 32'h0BADF00D, 4'h6);
        tick();
        chk("rstd.resume", TRACE_VALID, 1);
        check_model("rstd.resume");
        $display("[TB] reset mid-drain resumed head=%h", TRACE_DATA);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST   = ($urandom_range(0, 249) == 0);
            ST_EN = $urandom_range(0, 1);
            MADDR = ($urandom_range(0, 3) != 0) ? {WIN, 20'($urandom)} : $urandom;
            MDATAO = $urandom;
            MWSTB = 4'($urandom);
            PC_IF = ($urandom_range(0, 499) == 0) ? HPC : {$urandom} & 32'hFFFF_FFFC;
            if ((i / 300) % 2 == 0) TRACE_READY = ($urandom_range(0, 3) != 0);
            else                    TRACE_READY = ($urandom_range(0, 3) == 0);
            tick();
            check_model("rand");
            if (i % 500 == 499)
                $display("[TB] random cycles %0d: queued=%0d drop=%0d halted=%0b", i + 1, mq.size(), m_drop, m_halted);
        end
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
